// File: rtl/prime_lcd_pager.sv
// prime_lcd_pager
// Captures the prime stream from the sieve into a small synchronous buffer,
// then pages through the captured list one entry at a time. Each page is
// rendered as two 16-character ASCII rows for the LCD driver. Binary-to-BCD
// conversion is done serially with shift-add-3, so no divider is needed.
module prime_lcd_pager #(
    parameter int DEPTH_LOG2  = 8,
    parameter int HOLD_CYCLES = 50000000,
    parameter bit AUTO_ADV    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pr_valid,
    input  logic [9:0]            pr_data,
    input  logic                  sieve_done,
    input  logic                  btn_pulse,
    output logic [127:0]          row_A,
    output logic [127:0]          row_B,
    output logic                  row_upd,
    output logic [DEPTH_LOG2:0]   prime_cnt,
    output logic [DEPTH_LOG2-1:0] cur_idx,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int IW    = DEPTH_LOG2;
    localparam int TW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0]  CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);
    localparam logic [IW-1:0]  IDX_ONE    = IW'(1);
    localparam logic [IW-1:0]  IDX_ZERO   = IW'(0);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0]  TIMER_ZERO = TW'(0);

    localparam logic [127:0] STR_RUN   = "Sieve running...";
    localparam logic [127:0] STR_EMPTY = "No primes found ";
    localparam logic [127:0] STR_BLANK = {16{8'h20}};

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_EMPTY   = 3'd1,
        S_READ    = 3'd2,
        S_LOAD    = 3'd3,
        S_CONV    = 3'd4,
        S_SHOW    = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    // One BCD digit correction: digits of 5 or more get 3 added before the shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    // One shift-add-3 step on {3 BCD digits, 10-bit binary}.
    function automatic logic [21:0] dd_step_idx(input logic [21:0] x);
        logic [21:0] t;
        t = x;
        for (int n = 0; n < 3; n++) begin
            t[10 + 4*n +: 4] = add3(t[10 + 4*n +: 4]);
        end
        return t << 1'b1;
    endfunction

    // One shift-add-3 step on {4 BCD digits, 10-bit binary}.
    function automatic logic [25:0] dd_step_val(input logic [25:0] x);
        logic [25:0] t;
        t = x;
        for (int n = 0; n < 4; n++) begin
            t[10 + 4*n +: 4] = add3(t[10 + 4*n +: 4]);
        end
        return t << 1'b1;
    endfunction

    // BCD digit to its printable ASCII character.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_prime_cnt;
    logic [IW-1:0]   r_cur_idx;
    logic            r_overflow;
    logic            r_row_upd;
    logic [127:0]    r_row_a;
    logic [127:0]    r_row_b;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_conv_cnt;
    logic [21:0]     r_dd_idx;
    logic [25:0]     r_dd_val;
    logic            r_empty_shown;
    logic [9:0]      r_rd_data;
    logic [9:0]      r_mem [DEPTH];

    logic            w_full;
    logic            w_wr_en;
    logic [CW-1:0]   w_cnt_next;
    logic            w_timer_hit;
    logic            w_adv;
    logic [IW-1:0]   w_idx_next;
    logic [9:0]      w_page_num;

    // Capture enable, post-capture count, advance request and next page index.
    always_comb begin
        w_full      = (r_prime_cnt == CNT_FULL);
        w_wr_en     = 1'b0;
        w_cnt_next  = r_prime_cnt;
        w_timer_hit = 1'b0;
        w_adv       = 1'b0;
        w_idx_next  = r_cur_idx;
        w_page_num  = 10'(r_cur_idx) + 10'd1;

        if ((r_state == S_COLLECT) && pr_valid && !w_full) begin
            w_wr_en    = 1'b1;
            w_cnt_next = r_prime_cnt + CNT_ONE;
        end else begin
            w_wr_en    = 1'b0;
            w_cnt_next = r_prime_cnt;
        end

        w_timer_hit = (r_timer == TIMER_LAST);
        if (btn_pulse || (AUTO_ADV && w_timer_hit)) begin
            w_adv = 1'b1;
        end else begin
            w_adv = 1'b0;
        end

        // Last captured entry wraps to the first; a single entry stays at 0.
        if ({1'b0, r_cur_idx} == (r_prime_cnt - CNT_ONE)) begin
            w_idx_next = IDX_ZERO;
        end else begin
            w_idx_next = r_cur_idx + IDX_ONE;
        end
    end

    // Prime buffer: one write per captured prime, synchronous read of the displayed index.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_prime_cnt[IW-1:0]] <= pr_data;
        end
        r_rd_data <= r_mem[r_cur_idx];
    end

    // Main sequencer: capture, paging, serial BCD conversion and row formatting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_COLLECT;
            r_prime_cnt   <= CNT_ZERO;
            r_cur_idx     <= IDX_ZERO;
            r_overflow    <= 1'b0;
            r_row_upd     <= 1'b0;
            r_row_a       <= STR_RUN;
            r_row_b       <= STR_BLANK;
            r_timer       <= TIMER_ZERO;
            r_conv_cnt    <= 4'd0;
            r_dd_idx      <= 22'd0;
            r_dd_val      <= 26'd0;
            r_empty_shown <= 1'b0;
        end else begin
            r_row_upd <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    r_prime_cnt <= w_cnt_next;
                    if (pr_valid && w_full) begin
                        r_overflow <= 1'b1;
                    end
                    // A prime arriving with the done pulse is already in w_cnt_next.
                    if (sieve_done) begin
                        r_cur_idx <= IDX_ZERO;
                        if (w_cnt_next == CNT_ZERO) begin
                            r_state <= S_EMPTY;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_EMPTY: begin
                    if (!r_empty_shown) begin
                        r_row_a       <= STR_EMPTY;
                        r_row_b       <= STR_BLANK;
                        r_row_upd     <= 1'b1;
                        r_empty_shown <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_dd_idx   <= {12'h000, w_page_num};
                    r_dd_val   <= {16'h0000, r_rd_data};
                    r_conv_cnt <= 4'd0;
                    r_state    <= S_CONV;
                end
                S_CONV: begin
                    r_dd_idx   <= dd_step_idx(r_dd_idx);
                    r_dd_val   <= dd_step_val(r_dd_val);
                    r_conv_cnt <= r_conv_cnt + 4'd1;
                    if (r_conv_cnt == 4'd9) begin
                        r_state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    r_row_a   <= {"Prime #",
                                  to_ascii(r_dd_idx[21:18]),
                                  to_ascii(r_dd_idx[17:14]),
                                  to_ascii(r_dd_idx[13:10]),
                                  " is   "};
                    r_row_b   <= {"Value = ",
                                  to_ascii(r_dd_val[25:22]),
                                  to_ascii(r_dd_val[21:18]),
                                  to_ascii(r_dd_val[17:14]),
                                  to_ascii(r_dd_val[13:10]),
                                  "    "};
                    r_row_upd <= 1'b1;
                    r_timer   <= TIMER_ZERO;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    r_timer <= r_timer + TIMER_ONE;
                    if (w_adv) begin
                        r_cur_idx <= w_idx_next;
                        r_state   <= S_READ;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign row_A     = r_row_a;
    assign row_B     = r_row_b;
    assign row_upd   = r_row_upd;
    assign prime_cnt = r_prime_cnt;
    assign cur_idx   = r_cur_idx;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_prime_lcd_pager.sv
// Scoreboard bench for prime_lcd_pager: a button-only instance and an
// auto-advance instance (HOLD_CYCLES=8). Expected pages are pushed with the
// clock edge at which they must appear; monitors pop on every row_upd.
module tb_prime_lcd_pager;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         m_pr_valid, m_done, m_btn;
    logic [9:0]   m_pr_data;
    logic [127:0] m_row_A, m_row_B;
    logic         m_row_upd, m_overflow;
    logic [8:0]   m_prime_cnt;
    logic [7:0]   m_cur_idx;

    logic         a_pr_valid, a_done, a_btn;
    logic [9:0]   a_pr_data;
    logic [127:0] a_row_A, a_row_B;
    logic         a_row_upd, a_overflow;
    logic [8:0]   a_prime_cnt;
    logic [7:0]   a_cur_idx;

    prime_lcd_pager #(.DEPTH_LOG2(8), .HOLD_CYCLES(1000), .AUTO_ADV(1'b0)) u_dut (
        .clk(clk), .rst(rst), .pr_valid(m_pr_valid), .pr_data(m_pr_data),
        .sieve_done(m_done), .btn_pulse(m_btn), .row_A(m_row_A), .row_B(m_row_B),
        .row_upd(m_row_upd), .prime_cnt(m_prime_cnt), .cur_idx(m_cur_idx),
        .overflow(m_overflow)
    );

    prime_lcd_pager #(.DEPTH_LOG2(8), .HOLD_CYCLES(8), .AUTO_ADV(1'b1)) u_dut_auto (
        .clk(clk), .rst(rst), .pr_valid(a_pr_valid), .pr_data(a_pr_data),
        .sieve_done(a_done), .btn_pulse(a_btn), .row_A(a_row_A), .row_B(a_row_B),
        .row_upd(a_row_upd), .prime_cnt(a_prime_cnt), .cur_idx(a_cur_idx),
        .overflow(a_overflow)
    );

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [7:0]   idx;
        int           edge_n;
    } exp_t;

    exp_t q_m[$];
    exp_t q_a[$];
    int   m_list[$];
    int   a_list[$];
    int   primes[$];
    int   m_idx;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [127:0] str_run, str_empty, str_blank;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected page from the list contents: number is index+1, value in decimal.
    task automatic push_page(input int sel, input int idx, input int e);
        exp_t x;
        int   v;
        v = (sel == 0) ? m_list[idx] : a_list[idx];
        $sformat(x.a, "Prime #%03d is   ", idx + 1);
        $sformat(x.b, "Value = %04d    ", v);
        x.idx    = 8'(idx);
        x.edge_n = e;
        if (sel == 0) q_m.push_back(x);
        else          q_a.push_back(x);
    endtask

    task automatic mon(input int sel);
        logic         upd;
        logic [127:0] ra, rb;
        logic [7:0]   ci;
        exp_t         e;
        bit           have;
        string        nm;
        nm = (sel == 0) ? "main" : "auto";
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                upd = (sel == 0) ? m_row_upd : a_row_upd;
                if (upd === 1'b1) begin
                    ra = (sel == 0) ? m_row_A : a_row_A;
                    rb = (sel == 0) ? m_row_B : a_row_B;
                    ci = (sel == 0) ? m_cur_idx : a_cur_idx;
                    have = (sel == 0) ? (q_m.size() > 0) : (q_a.size() > 0);
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL %s_unexpected_upd at edge %0d row_A \"%s\" expected no update", nm, cyc, ra);
                    end else begin
                        if (sel == 0) e = q_m.pop_front();
                        else          e = q_a.pop_front();
                        check({nm, "_row_A"}, ra, e.a);
                        check({nm, "_row_B"}, rb, e.b);
                        check({nm, "_cur_idx"}, 128'(ci), 128'(e.idx));
                        check({nm, "_upd_edge"}, 128'(cyc), 128'(e.edge_n));
                    end
                end
            end
        end
    endtask

    task automatic drain(input int sel, input int limit);
        int n;
        n = 0;
        while (((sel == 0) ? q_m.size() : q_a.size()) > 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (((sel == 0) ? q_m.size() : q_a.size()) > 0) begin
            errors++;
            $display("FAIL drain_%0d got %0d pending pages expected 0", sel, (sel == 0) ? q_m.size() : q_a.size());
            if (sel == 0) q_m.delete();
            else          q_a.delete();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        m_pr_valid = 1'b0; m_done = 1'b0; m_btn = 1'b0; m_pr_data = 10'd0;
        a_pr_valid = 1'b0; a_done = 1'b0; a_btn = 1'b0; a_pr_data = 10'd0;
        q_m.delete(); q_a.delete(); m_list.delete(); a_list.delete();
        m_idx = 0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic m_expect_first(input int e);
        exp_t x;
        m_idx = 0;
        if (m_list.size() == 0) begin
            x.a = str_empty; x.b = str_blank; x.idx = 8'd0; x.edge_n = e + 1;
            q_m.push_back(x);
        end else begin
            push_page(0, 0, e + 13);
        end
    endtask

    task automatic m_send(input int v, input bit done);
        m_pr_valid = 1'b1;
        m_pr_data  = 10'(v);
        m_done     = done;
        if (m_list.size() < 256) m_list.push_back(v);
        if (done) m_expect_first(cyc + 1);
        tick();
        m_pr_valid = 1'b0;
        m_done     = 1'b0;
    endtask

    task automatic m_done_only();
        m_done = 1'b1;
        m_expect_first(cyc + 1);
        tick();
        m_done = 1'b0;
    endtask

    task automatic m_press();
        m_btn = 1'b1;
        m_idx = (m_idx == m_list.size() - 1) ? 0 : m_idx + 1;
        push_page(0, m_idx, cyc + 1 + 13);
        tick();
        m_btn = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_row_A"}, m_row_A, str_run);
        check({tag, "_row_B"}, m_row_B, str_blank);
        check({tag, "_prime_cnt"}, 128'(m_prime_cnt), 128'd0);
        check({tag, "_overflow"}, 128'(m_overflow), 128'd0);
        check({tag, "_row_upd"}, 128'(m_row_upd), 128'd0);
        check({tag, "_cur_idx"}, 128'(m_cur_idx), 128'd0);
    endtask

    initial begin
        bit ok;
        int d;
        str_run   = "Sieve running...";
        str_empty = "No primes found ";
        str_blank = {16{8'h20}};
        for (int n = 2; n <= 1021; n++) begin
            ok = 1'b1;
            for (int k = 2; k * k <= n; k++) if (n % k == 0) ok = 1'b0;
            if (ok) primes.push_back(n);
        end

        do_reset(0);
        rst = 1'b0;
        fork
            mon(0);
            mon(1);
        join_none
        repeat (2) tick();
        check_reset_state("t1_reset");
        check("t1_auto_row_A", a_row_A, str_run);
        rst = 1'b1;
        tick();

        // Done with an empty list: terminal page, later inputs ignored.
        m_done_only();
        drain(0, 20);
        m_btn = 1'b1; m_pr_valid = 1'b1; m_pr_data = 10'd5; m_done = 1'b1;
        tick();
        m_btn = 1'b0; m_pr_valid = 1'b0; m_done = 1'b0;
        repeat (20) tick();
        check("t6_empty_row_A", m_row_A, str_empty);
        check("t6_empty_row_B", m_row_B, str_blank);
        check("t6_empty_cnt", 128'(m_prime_cnt), 128'd0);

        // Four primes, first page, button paging with wrap.
        do_reset(2);
        foreach (primes[i]) begin
            if (i < 4) begin
                m_send(primes[i], 1'b0);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        m_done_only();
        check("t2_prime_cnt", 128'(m_prime_cnt), 128'd4);
        drain(0, 30);
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(0, 5)) tick();
            m_press();
            drain(0, 30);
        end
        check("t3_wrap_idx", 128'(m_cur_idx), 128'd0);
        // Button during CONV and pr_valid during paging are ignored.
        m_press();
        repeat (4) tick();
        m_btn = 1'b1; m_pr_valid = 1'b1; m_pr_data = 10'd11;
        tick();
        m_btn = 1'b0; m_pr_valid = 1'b0;
        drain(0, 30);
        repeat (20) tick();
        check("t3_cnt_after_ignore", 128'(m_prime_cnt), 128'd4);
        check("t3_idx_after_ignore", 128'(m_cur_idx), 128'(m_idx));
        // Reset while converting aborts the page.
        m_press();
        repeat (4) tick();
        do_reset(1);
        check_reset_state("t6_mid_conv");
        repeat (20) tick();
        check("t6_mid_conv_row_A_hold", m_row_A, str_run);

        // Full list of 172 primes, last one arriving with the done pulse.
        do_reset(2);
        foreach (primes[i]) begin
            m_send(primes[i], (i == primes.size() - 1));
            if (i != primes.size() - 1) repeat ($urandom_range(0, 1)) tick();
        end
        check("t4_prime_cnt", 128'(m_prime_cnt), 128'(primes.size()));
        drain(0, 30);
        for (int p = 0; p < primes.size(); p++) begin
            repeat ($urandom_range(0, 2)) tick();
            m_press();
            drain(0, 30);
            if (p == primes.size() - 2) check("t4_last_idx", 128'(m_cur_idx), 128'd171);
        end

        // Overflow: 257 random values, the last one dropped.
        do_reset(2);
        for (int i = 0; i < 257; i++) begin
            m_send($urandom_range(2, 1021), 1'b0);
            if (i == 255) check("t5_no_ovf_at_256", 128'(m_overflow), 128'd0);
        end
        check("t5_prime_cnt", 128'(m_prime_cnt), 128'd256);
        check("t5_overflow", 128'(m_overflow), 128'd1);
        m_done_only();
        drain(0, 30);
        for (int p = 0; p < 256; p++) begin
            m_press();
            drain(0, 30);
        end

        // Single prime: advancing refreshes the same page.
        do_reset(2);
        m_send($urandom_range(2, 1021), 1'b0);
        m_done_only();
        drain(0, 30);
        for (int p = 0; p < 2; p++) begin
            repeat ($urandom_range(0, 3)) tick();
            m_press();
            drain(0, 30);
        end

        // Auto-advance instance: a page every 8+13 edges after the first.
        for (int i = 0; i < 3; i++) begin
            a_list.push_back($urandom_range(2, 1021));
            a_pr_valid = 1'b1;
            a_pr_data  = 10'(a_list[i]);
            tick();
            a_pr_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        a_done = 1'b1;
        d = cyc + 1;
        for (int k = 0; k < 5; k++) push_page(1, k % 3, d + 13 + 21 * k);
        tick();
        a_done = 1'b0;
        check("t6_auto_cnt", 128'(a_prime_cnt), 128'd3);
        drain(1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
